// File: rtl/frequency_sequencer_pkg.sv
// Shared definitions for the frequency measurement sequencer.
// Holds the FSM state encoding and the register-file operation codes understood by
// axi_slave_impl.
package frequency_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StClear     = 3'd1,
    StMeasure   = 3'd2,
    StSettle    = 3'd3,
    StWriteback = 3'd4,
    StDone      = 3'd5
  } sequencer_state_e;

  localparam logic [1:0] REGISTER_IDLE_OPERATION  = 2'd0;
  localparam logic [1:0] REGISTER_WRITE_OPERATION = 2'd2;

endpackage

// File: rtl/measurement_window_timer.sv
// Loadable 32-bit down-counter.
// Ports:
//   clock       - clock
//   reset       - synchronous, active-high
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value loaded; the terminal count is reached load_value cycles later
//   count       - current count
//   terminal    - high while the count is zero
// Loading N-1 therefore times an interval of exactly N cycles.
module measurement_window_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] count,
  output logic        terminal
);

  logic [31:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == '0);

endmodule

// File: rtl/frequency_measurement_sequencer.sv
// Measurement-cycle sequencer in front of the frequency_analyzer instances and the
// axi_slave_impl register file. One software trigger runs: clear analyzers (1 cycle),
// enable them for WINDOW_CYCLES, settle for SETTLE_CYCLES, write NUMBER_OF_REGISTERS results
// (HOLD_CYCLES each), then hold irq until irq_ack. abort returns to idle from any busy state.
// Ports:
//   clock, reset (sync, active-high), trigger, abort, irq_ack       - control inputs
//   analyzer_enable, analyzer_clear_n                                 - analyzer control
//   result_index / result_value                                       - result mux select / data
//   register_operation, register_number, register_write               - register-file write port
//   busy, irq                                                         - status
// Build option: define MEASUREMENT_COUNTER_EN to append a completed-cycle counter as
// register NUMBER_OF_REGISTERS+1.
module frequency_measurement_sequencer
  import frequency_sequencer_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES       = 100000000,
  parameter int unsigned NUMBER_OF_REGISTERS = 7,
  parameter int unsigned HOLD_CYCLES         = 4,
  parameter int unsigned SETTLE_CYCLES       = 2,
  parameter int unsigned DATA_WIDTH          = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic                  irq_ack,
  output logic                  analyzer_enable,
  output logic                  analyzer_clear_n,
  output logic [7:0]            result_index,
  input  logic [DATA_WIDTH-1:0] result_value,
  output logic [1:0]            register_operation,
  output logic [7:0]            register_number,
  output logic [DATA_WIDTH-1:0] register_write,
  output logic                  busy,
  output logic                  irq
);

`ifdef MEASUREMENT_COUNTER_EN
  localparam int unsigned SlotCount = NUMBER_OF_REGISTERS + 1;
  logic [31:0] measurement_count_q;
`else
  localparam int unsigned SlotCount = NUMBER_OF_REGISTERS;
`endif
  localparam logic [7:0] LastResult = 8'(NUMBER_OF_REGISTERS);
  localparam logic [7:0] LastSlot   = 8'(SlotCount);

  sequencer_state_e state_q;

  logic        timer_load;
  logic [31:0] timer_value;
  logic [31:0] timer_count;
  logic        timer_terminal;
  logic [7:0]  next_number;
  logic [7:0]  lead_index;
  logic [7:0]  next_lead_index;

  measurement_window_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .terminal   (timer_terminal)
  );

  // The write data is captured on entry to each slot, so the mux select is advanced to the
  // next slot's index during the final cycle of the current slot (0 when no result follows).
  assign next_number     = register_number + 8'd1;
  assign lead_index      = (register_number < LastResult) ? register_number + 8'd1 : 8'd0;
  assign next_lead_index = (next_number < LastResult) ? next_number + 8'd1 : 8'd0;

  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state_q)
      StClear: begin
        timer_load  = 1'b1;
        timer_value = 32'(WINDOW_CYCLES - 1);
      end
      StMeasure: begin
        timer_load  = timer_terminal;
        timer_value = 32'(SETTLE_CYCLES - 1);
      end
      StSettle, StWriteback: begin
        timer_load  = timer_terminal && !(state_q == StWriteback && register_number == LastSlot);
        timer_value = 32'(HOLD_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || (abort && state_q != StIdle)) begin
      state_q            <= StIdle;
      analyzer_enable    <= 1'b0;
      analyzer_clear_n   <= 1'b1;
      result_index       <= 8'd0;
      register_operation <= REGISTER_IDLE_OPERATION;
      register_number    <= 8'd0;
      register_write     <= '0;
`ifdef MEASUREMENT_COUNTER_EN
      if (reset) measurement_count_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger && !abort) begin
            state_q          <= StClear;
            analyzer_clear_n <= 1'b0;
          end
        end
        StClear: begin
          state_q          <= StMeasure;
          analyzer_clear_n <= 1'b1;
          analyzer_enable  <= 1'b1;
        end
        StMeasure: begin
          if (timer_terminal) begin
            state_q         <= StSettle;
            analyzer_enable <= 1'b0;
            result_index    <= 8'd1;
          end
        end
        StSettle: begin
          if (timer_terminal) begin
            state_q            <= StWriteback;
            register_operation <= REGISTER_WRITE_OPERATION;
            register_number    <= 8'd1;
            register_write     <= result_value;
            if (HOLD_CYCLES == 1) result_index <= (LastResult > 8'd1) ? 8'd2 : 8'd0;
          end
        end
        StWriteback: begin
          if (timer_terminal) begin
            if (register_number == LastSlot) begin
              state_q            <= StDone;
              register_operation <= REGISTER_IDLE_OPERATION;
              register_number    <= 8'd0;
              result_index       <= 8'd0;
`ifdef MEASUREMENT_COUNTER_EN
              measurement_count_q <= measurement_count_q + 32'd1;
`endif
            end else begin
              register_number <= next_number;
`ifdef MEASUREMENT_COUNTER_EN
              if (next_number > LastResult) begin
                register_write <= DATA_WIDTH'(measurement_count_q + 32'd1);
              end else begin
                register_write <= result_value;
              end
`else
              register_write <= result_value;
`endif
              if (HOLD_CYCLES == 1) result_index <= next_lead_index;
            end
          end else if (timer_count == 32'd1) begin
            result_index <= lead_index;
          end
        end
        StDone: begin
          if (irq_ack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign irq  = (state_q == StDone);

endmodule
